// File: rtl/data_ram_be.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_be
//  Description : Single-port, word-addressed data memory with byte-lane
//                write enables, a 1-cycle registered read, a valid/ready
//                request interface and a post-reset hardware clear sweep
//                that writes CLEAR_VALUE into every word, one per cycle.
//
//  Ports
//    clock       : single clock, all state updates on its rising edge
//    reset       : synchronous, active-high; restarts the clear sweep
//    req_valid   : request present this cycle
//    req_ready   : block can accept a request (high only when idle)
//    req_write   : 1 = write, 0 = read
//    req_addr    : word index
//    req_wdata   : write data
//    req_be      : byte enables, bit k covers bits [8k+7:8k]
//    resp_valid  : one-cycle pulse, read data valid
//    resp_rdata  : read data, held until the next read response
//    busy        : clear sweep in progress
//
//  Revision    : 1.0 - initial release
// ============================================================================
module data_ram_be #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 5,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    busy
);

    localparam int                  c_NUM_LANES = DATA_WIDTH / 8;
    localparam int                  c_DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE =
        {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_clear_ptr;
    logic                    r_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_rdata;
    logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];

    logic                    w_idle;
    logic                    w_accept;
    logic                    w_clear_we;
    logic                    w_req_we;

    // Ready and busy depend on state only, so there is no combinational
    // path from the request inputs to any output.
    assign w_idle    = (r_state == ST_IDLE);
    assign req_ready = w_idle;
    assign busy      = ~w_idle;

    assign w_accept  = req_valid & w_idle;

    // The reset cycle itself must leave memory untouched, hence the
    // explicit ~reset qualification on both write sources.
    assign w_clear_we = ~reset & ~w_idle;
    assign w_req_we   = ~reset & w_accept & req_write;

    // ------------------------------------------------------------------
    // Control FSM with registered read response.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_CLEAR;
            r_clear_ptr  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_clear_ptr <= r_clear_ptr + c_PTR_ONE;
                    if (r_clear_ptr == c_LAST_ADDR) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_accept && !req_write) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_mem[req_addr];
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage. The sweep writes whole words; requests write only the
    // enabled byte lanes so untouched lanes keep their value.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_clear_we) begin
            r_mem[r_clear_ptr] <= CLEAR_VALUE;
        end else if (w_req_we) begin
            for (int k = 0; k < c_NUM_LANES; k++) begin
                if (req_be[k]) begin
                    r_mem[req_addr][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;

`ifndef SYNTHESIS
    // Write trace for simulation debugging.
    always @(posedge clock) begin
        if (w_req_we) begin
            $display("data_ram_be: write addr=%0d be=%b data=%h",
                     req_addr, req_be, req_wdata);
        end
    end
`endif

endmodule
`default_nettype wire
